ip2_scan_capture: RTL and testbench
===================================

Name: ip2_scan_capture

Overview:
- Parametrised successor to the IP2 scan-chain test state machine.
- Drives reset_not, scan_load and scan_in to the ASIC scan chain. Latches the comparators in parallel, then serially shifts the chain out.
- Captures the returned scan_out bits into an internal word-addressable buffer and accumulates DNN output hit counts over a programmable number of frames.
- Sits beside the other ip2_testN blocks under the firmware test multiplexer and is selected by enable.

Parameters:
- CHAIN_LEN, 768, scan-chain length in bits (multiple of 32, max 4096).
- N_DNN, 2, number of DNN output channels counted.
- CNT_W, 6, width of the shared clk_counter / phase inputs.
- FRAME_W, 8, width of the frame-count input.

Ports:
- clk  in  1  firmware clock (400 MHz).
- reset  in  1  synchronous, active-high.
- enable  in  1  block select; low acts exactly as reset.
- clk_counter  in  CNT_W  free-running slot phase counter.
- test_delay  in  CNT_W  slot-end phase.
- test_trig_out_phase  in  CNT_W  trigger edge phase.
- test_mask_reset_not  in  1  1 = suppress the ASIC reset pulse.
- start_re  in  1  one-cycle start pulse.
- n_frames  in  FRAME_W  frames per run; 0 is treated as 1.
- pattern_bit  in  1  value driven on scan_in during shift.
- scan_out  in  1  ASIC scan-chain serial output.
- dnn_output  in  N_DNN  ASIC DNN outputs.
- rd_addr  in  clog2(CHAIN_LEN/32)  capture buffer word address.
- rd_data  out  32  capture buffer word; bit k = chain bit 32*rd_addr+k; registered, 1-cycle latency.
- o_reset_not  out  1  ASIC reset, active low.
- o_scan_load  out  1  SCAN_REG_MODE_LOAD_COMP (1) or SCAN_REG_MODE_SHIFT_IN (0).
- o_scan_in  out  1  serial data to the ASIC.
- o_trig_out  out  1  injection trigger.
- o_busy  out  1  high in every state other than IDLE.
- o_done  out  1  sticky done flag.
- o_frame_cnt  out  FRAME_W  frames completed.
- o_dnn_hits  out  N_DNN*32  per-channel hit counters.
- o_state  out  state_t_sm_ip2_scan_capture  current state.

Behaviour:
- Slot definition: a slot ends on the cycle where clk_counter==test_delay ("slot_end"). All state transitions happen only at slot_end, except DONE->IDLE.
- Reset or enable low (synchronous, active-high):
  - state=IDLE, o_reset_not=1, o_scan_load=1, o_scan_in=0, o_trig_out=0.
  - o_busy=0, o_done=0, o_frame_cnt=0, all hit counters 0.
  - Capture buffer contents are not cleared.
  - Reset mid-run aborts immediately; outputs reach these values on the next edge.
- IDLE: on start_re go to DELAY. Also clear o_done, o_frame_cnt, hit counters, bit index and frames_left (set to n_frames, or 1 if n_frames==0). start_re in any other state is ignored.
- DELAY: at slot_end go to RESETN; o_reset_not<=test_mask_reset_not and o_scan_load<=0 on that edge.
- RESETN: holds the reset for one slot. At slot_end go to LOAD1 with o_reset_not<=1, o_scan_load<=1.
- LOAD1: one full slot with scan_load high (comparator load). o_trig_out<=1 on the cycle where clk_counter==test_trig_out_phase.
- LOAD2: o_trig_out<=0 on the cycle where clk_counter==test_trig_out_phase.
  - At slot_end: sample dnn_output and increment each channel counter whose bit is 1 (saturating at 2^32-1).
  - Also at slot_end: o_scan_load<=0, o_scan_in<=pattern_bit, bit_idx<=0, then go to SHIFT.
- SHIFT: o_scan_load=0, o_scan_in=pattern_bit.
  - At each slot_end: write scan_out into buffer bit bit_idx, then bit_idx++.
  - When the write at bit_idx==CHAIN_LEN-1 occurs: o_frame_cnt++ and frames_left--.
    - If frames_left was 1: go to DONE with o_scan_load<=1.
    - Otherwise: go to LOAD1 with o_scan_load<=1. RESETN is skipped on repeat frames.
- DONE: o_done<=1 (sticky until the next start or reset); o_scan_load=1; next cycle goes to IDLE.
- Unknown state: go to IDLE.
- Buffer read and write:
  - Synchronous single-port write.
  - rd_data is registered. A read of the word currently being written returns the pre-write value.
- Counter widths:
  - bit_idx is clog2(CHAIN_LEN) bits with no wrap.
  - o_frame_cnt saturates at all-ones.

Decomposition:
- Add to cms_pix28_package:
  - state_t_sm_ip2_scan_capture with states IDLE, DELAY, RESETN, LOAD1, LOAD2, SHIFT, DONE.
  - The existing SCAN_REG_MODE_* constants.
- One sub-module, ip2_scan_capture_buf: CHAIN_LEN-bit bit-write / word-read memory with registered read.

Test Plan:
- CHAIN_LEN=64, test_delay=10, n_frames=1, mask=0, scan_out = alternating 1,0:
  - o_reset_not low for exactly one slot.
  - 64 shift slots, then o_done=1.
  - rd_data[0] = 0x55555555 and rd_data[1] = 0x55555555; o_frame_cnt=1.
- n_frames=3, dnn_output=2'b01 held -> o_dnn_hits ch0=3, ch1=0; o_frame_cnt=3; RESETN visited once.
- mask=1 -> o_reset_not never goes low; all other timing is unchanged.
- test_trig_out_phase=5 -> o_trig_out rises at phase 5 in LOAD1 and falls at phase 5 in LOAD2, once per frame.
- enable dropped at bit_idx=20 -> next edge: IDLE, o_busy=0, o_done=0, o_scan_load=1. A later start completes normally.
- start_re pulsed during SHIFT -> ignored; n_frames=0 -> exactly one frame.

Source files
------------

// File: rtl/ip2_scan_capture_pkg.sv
// Shared types and constants for the IP2 scan-chain capture block.
// Holds the FSM state type, scan_load mode codes and a buffer address-width helper.
package cms_pix28_package;

    localparam logic SCAN_REG_MODE_LOAD_COMP = 1'b1;
    localparam logic SCAN_REG_MODE_SHIFT_IN  = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        RESETN = 3'd2,
        LOAD1  = 3'd3,
        LOAD2  = 3'd4,
        SHIFT  = 3'd5,
        DONE   = 3'd6
    } state_t_sm_ip2_scan_capture;

    // Word-address width of the capture buffer; never narrower than 1 bit.
    function automatic int buf_aw(input int chain_len);
        int words;
        words = chain_len / 32;
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/ip2_scan_capture_buf.sv
// Capture buffer: CHAIN_LEN bits written one bit at a time, read as 32-bit words.
// Ports: clk, we_i/wr_bit_i/wr_data_i (bit write), rd_addr_i -> rd_data_o (registered).
module ip2_scan_capture_buf
    import cms_pix28_package::*;
#(
    parameter int CHAIN_LEN = 768
) (
    input  logic                              clk,
    input  logic                              we_i,
    input  logic [buf_aw(CHAIN_LEN)+4:0]      wr_bit_i,
    input  logic                              wr_data_i,
    input  logic [buf_aw(CHAIN_LEN)-1:0]      rd_addr_i,
    output logic [31:0]                       rd_data_o
);

    localparam int WORDS = CHAIN_LEN / 32;
    localparam int AW    = buf_aw(CHAIN_LEN);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rd_data_q;

    // Read and write share an edge, so a read of the word being written
    // returns its old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_bit_i[AW+4:5]][wr_bit_i[4:0]] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ip2_scan_capture.sv
// IP2 scan-chain test sequencer: resets the ASIC, loads comparators, shifts the chain
// out into a capture buffer and counts DNN hits over n_frames frames.
module ip2_scan_capture
    import cms_pix28_package::*;
#(
    parameter int CHAIN_LEN = 768,
    parameter int N_DNN     = 2,
    parameter int CNT_W     = 6,
    parameter int FRAME_W   = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [CNT_W-1:0]                 clk_counter,
    input  logic [CNT_W-1:0]                 test_delay,
    input  logic [CNT_W-1:0]                 test_trig_out_phase,
    input  logic                             test_mask_reset_not,
    input  logic                             start_re,
    input  logic [FRAME_W-1:0]               n_frames,
    input  logic                             pattern_bit,
    input  logic                             scan_out,
    input  logic [N_DNN-1:0]                 dnn_output,
    input  logic [buf_aw(CHAIN_LEN)-1:0]     rd_addr,
    output logic [31:0]                      rd_data,
    output logic                             o_reset_not,
    output logic                             o_scan_load,
    output logic                             o_scan_in,
    output logic                             o_trig_out,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [FRAME_W-1:0]               o_frame_cnt,
    output logic [N_DNN*32-1:0]              o_dnn_hits,
    output state_t_sm_ip2_scan_capture       o_state
);

    localparam int IW = buf_aw(CHAIN_LEN) + 5;
    localparam logic [IW-1:0] LAST_BIT = IW'(CHAIN_LEN - 1);

    state_t_sm_ip2_scan_capture state_q, state_d;
    logic               reset_not_q, reset_not_d;
    logic               scan_load_q, scan_load_d;
    logic               scan_in_q, scan_in_d;
    logic               trig_q, trig_d;
    logic               done_q, done_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [FRAME_W-1:0] frames_left_q, frames_left_d;
    logic [IW-1:0]      bit_idx_q, bit_idx_d;
    logic [31:0]        hits_q [N_DNN];
    logic [31:0]        hits_d [N_DNN];
    logic               buf_we;
    logic               slot_end;
    logic               trig_hit;

    assign slot_end = (clk_counter == test_delay);
    assign trig_hit = (clk_counter == test_trig_out_phase);

    always_comb begin
        state_d       = state_q;
        reset_not_d   = reset_not_q;
        scan_load_d   = scan_load_q;
        scan_in_d     = scan_in_q;
        trig_d        = trig_q;
        done_d        = done_q;
        frame_cnt_d   = frame_cnt_q;
        frames_left_d = frames_left_q;
        bit_idx_d     = bit_idx_q;
        hits_d        = hits_q;
        buf_we        = 1'b0;
        if (reset || !enable) begin
            state_d       = IDLE;
            reset_not_d   = 1'b1;
            scan_load_d   = SCAN_REG_MODE_LOAD_COMP;
            scan_in_d     = 1'b0;
            trig_d        = 1'b0;
            done_d        = 1'b0;
            frame_cnt_d   = '0;
            frames_left_d = '0;
            bit_idx_d     = '0;
            for (int i = 0; i < N_DNN; i++) hits_d[i] = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_re) begin
                        state_d       = DELAY;
                        done_d        = 1'b0;
                        frame_cnt_d   = '0;
                        bit_idx_d     = '0;
                        frames_left_d = (n_frames == '0) ? FRAME_W'(1) : n_frames;
                        for (int i = 0; i < N_DNN; i++) hits_d[i] = '0;
                    end
                end
                DELAY: begin
                    if (slot_end) begin
                        state_d     = RESETN;
                        reset_not_d = test_mask_reset_not;
                        scan_load_d = SCAN_REG_MODE_SHIFT_IN;
                    end
                end
                RESETN: begin
                    if (slot_end) begin
                        state_d     = LOAD1;
                        reset_not_d = 1'b1;
                        scan_load_d = SCAN_REG_MODE_LOAD_COMP;
                    end
                end
                LOAD1: begin
                    if (trig_hit) trig_d = 1'b1;
                    if (slot_end) state_d = LOAD2;
                end
                LOAD2: begin
                    if (trig_hit) trig_d = 1'b0;
                    if (slot_end) begin
                        for (int i = 0; i < N_DNN; i++) begin
                            if (dnn_output[i] && hits_q[i] != '1)
                                hits_d[i] = hits_q[i] + 32'd1;
                        end
                        scan_load_d = SCAN_REG_MODE_SHIFT_IN;
                        scan_in_d   = pattern_bit;
                        bit_idx_d   = '0;
                        state_d     = SHIFT;
                    end
                end
                SHIFT: begin
                    scan_load_d = SCAN_REG_MODE_SHIFT_IN;
                    scan_in_d   = pattern_bit;
                    if (slot_end) begin
                        buf_we = 1'b1;
                        if (bit_idx_q == LAST_BIT) begin
                            if (frame_cnt_q != '1)
                                frame_cnt_d = frame_cnt_q + 1'b1;
                            frames_left_d = frames_left_q - 1'b1;
                            scan_load_d   = SCAN_REG_MODE_LOAD_COMP;
                            // Repeat frames go straight back to comparator load.
                            state_d = (frames_left_q == FRAME_W'(1)) ? DONE : LOAD1;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_d      = 1'b1;
                    scan_load_d = SCAN_REG_MODE_LOAD_COMP;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        reset_not_q   <= reset_not_d;
        scan_load_q   <= scan_load_d;
        scan_in_q     <= scan_in_d;
        trig_q        <= trig_d;
        done_q        <= done_d;
        frame_cnt_q   <= frame_cnt_d;
        frames_left_q <= frames_left_d;
        bit_idx_q     <= bit_idx_d;
        hits_q        <= hits_d;
    end

    ip2_scan_capture_buf #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_buf (
        .clk       (clk),
        .we_i      (buf_we),
        .wr_bit_i  (bit_idx_q),
        .wr_data_i (scan_out),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    for (genvar g = 0; g < N_DNN; g++) begin : g_hits
        assign o_dnn_hits[32*g +: 32] = hits_q[g];
    end

    assign o_reset_not = reset_not_q;
    assign o_scan_load = scan_load_q;
    assign o_scan_in   = scan_in_q;
    assign o_trig_out  = trig_q;
    assign o_busy      = (state_q != IDLE);
    assign o_done      = done_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_ip2_scan_capture.sv
// Testbench for ip2_scan_capture: slot-count reference model plus directed runs.
// CHAIN_LEN=64, slot length 16 cycles (clk_counter counts 0..15).
module tb_ip2_scan_capture;
    import cms_pix28_package::*;

    localparam int CL = 64;
    localparam int ND = 2;
    localparam int CW = 6;
    localparam int FW = 8;
    localparam int FRAME_SLOTS = CL + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [CW-1:0] clk_counter = '0;
    logic [CW-1:0] test_delay;
    logic [CW-1:0] test_trig_out_phase;
    logic          test_mask_reset_not;
    logic          start_re;
    logic [FW-1:0] n_frames;
    logic          pattern_bit;
    logic          scan_out = 1'b0;
    logic [ND-1:0] dnn_output;
    logic [0:0]    rd_addr;
    logic [31:0]   rd_data;
    logic          o_reset_not, o_scan_load, o_scan_in, o_trig_out;
    logic          o_busy, o_done;
    logic [FW-1:0] o_frame_cnt;
    logic [ND*32-1:0] o_dnn_hits;
    state_t_sm_ip2_scan_capture o_state;

    always #5 clk = ~clk;

    ip2_scan_capture #(
        .CHAIN_LEN (CL), .N_DNN (ND), .CNT_W (CW), .FRAME_W (FW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .clk_counter         (clk_counter),
        .test_delay          (test_delay),
        .test_trig_out_phase (test_trig_out_phase),
        .test_mask_reset_not (test_mask_reset_not),
        .start_re            (start_re),
        .n_frames            (n_frames),
        .pattern_bit         (pattern_bit),
        .scan_out            (scan_out),
        .dnn_output          (dnn_output),
        .rd_addr             (rd_addr),
        .rd_data             (rd_data),
        .o_reset_not         (o_reset_not),
        .o_scan_load         (o_scan_load),
        .o_scan_in           (o_scan_in),
        .o_trig_out          (o_trig_out),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_frame_cnt         (o_frame_cnt),
        .o_dnn_hits          (o_dnn_hits),
        .o_state             (o_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a run is a count of slot ends since start.
    // Slot 0 = DELAY, slot 1 = RESETN, then per frame LOAD1, LOAD2, CL shift slots.
    bit          m_run = 0;
    bit          m_donecyc = 0;
    bit          m_done = 0;
    bit          m_trig = 0;
    int          m_s = 0;
    int          m_nf = 1;
    logic [FW-1:0] m_fcnt = '0;
    logic [31:0] m_hits [ND];
    logic        m_mem [CL];
    bit          so_rand = 0;
    bit          cmp_en = 0;
    int          lowcnt = 0;
    int          rstcyc = 0;
    int          rises = 0;
    logic        trig_prev = 1'b0;

    function automatic state_t_sm_ip2_scan_capture exp_state();
        int r;
        if (m_donecyc) return DONE;
        if (!m_run) return IDLE;
        if (m_s == 0) return DELAY;
        if (m_s == 1) return RESETN;
        r = (m_s - 2) % FRAME_SLOTS;
        if (r == 0) return LOAD1;
        if (r == 1) return LOAD2;
        return SHIFT;
    endfunction

    function automatic int exp_bit();
        return (m_s - 2) % FRAME_SLOTS - 2;
    endfunction

    always @(posedge clk) begin : mdl
        state_t_sm_ip2_scan_capture st;
        int b;
        st = exp_state();
        if (reset || !enable) begin
            m_run = 0; m_donecyc = 0; m_done = 0; m_trig = 0; m_fcnt = '0;
            for (int i = 0; i < ND; i++) m_hits[i] = '0;
        end else begin
            if (clk_counter == test_trig_out_phase) begin
                if (st == LOAD1) m_trig = 1;
                if (st == LOAD2) m_trig = 0;
            end
            if (st == IDLE) begin
                if (start_re) begin
                    m_run = 1; m_s = 0; m_done = 0; m_fcnt = '0;
                    m_nf = (n_frames == '0) ? 1 : int'(n_frames);
                    for (int i = 0; i < ND; i++) m_hits[i] = '0;
                end
            end else if (st == DONE) begin
                m_donecyc = 0;
                m_done = 1;
            end else if (clk_counter == test_delay) begin
                if (st == LOAD2)
                    for (int i = 0; i < ND; i++)
                        if (dnn_output[i]) m_hits[i] = m_hits[i] + 1;
                if (st == SHIFT) begin
                    b = exp_bit();
                    m_mem[b] = scan_out;
                    if (b == CL - 1) begin
                        m_fcnt = m_fcnt + 1;
                        if (int'(m_fcnt) == m_nf) begin
                            m_run = 0;
                            m_donecyc = 1;
                        end
                    end
                end
                m_s++;
            end
        end
    end

    // Free-running slot phase, 16 cycles per slot.
    always @(negedge clk)
        clk_counter = (clk_counter == CW'(15)) ? '0 : clk_counter + 1'b1;

    // Alternating mode: chain bit k returns 1 for even k.
    always @(negedge clk) begin
        if (so_rand) scan_out = 1'($urandom);
        else scan_out = (exp_state() == SHIFT) && (exp_bit() % 2 == 0);
    end

    always @(negedge clk) begin : cmp
        state_t_sm_ip2_scan_capture st;
        if (cmp_en) begin
            st = exp_state();
            chk("state", 64'(o_state), 64'(st));
            chk("busy", 64'(o_busy), 64'(st != IDLE));
            chk("scan_load", 64'(o_scan_load), 64'(!(st == RESETN || st == SHIFT)));
            chk("reset_not", 64'(o_reset_not),
                64'(!(st == RESETN && !test_mask_reset_not)));
            chk("trig_out", 64'(o_trig_out), 64'(m_trig));
            chk("done", 64'(o_done), 64'(m_done));
            chk("frame_cnt", 64'(o_frame_cnt), 64'(m_fcnt));
            chk("dnn_hits", o_dnn_hits, {m_hits[1], m_hits[0]});
            if (st == SHIFT) chk("scan_in", 64'(o_scan_in), 64'(pattern_bit));
            if (!o_reset_not) lowcnt++;
            if (o_state == RESETN) rstcyc++;
            if (o_trig_out && !trig_prev) rises++;
            trig_prev = o_trig_out;
        end
    end

    task automatic start_run();
        @(negedge clk) start_re = 1'b1;
        @(negedge clk) start_re = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_done && o_state == IDLE) begin
                ok = 1;
                break;
            end
        end
        chk("done_timeout", 64'(ok), 64'(1));
    endtask

    task automatic wait_bit(input int bitn, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_state() == SHIFT && exp_bit() == bitn) begin
                ok = 1;
                break;
            end
        end
        chk("bit_timeout", 64'(ok), 64'(1));
    endtask

    task automatic rd_chk(input int w, input logic [31:0] lit, input bit use_lit);
        logic [31:0] e;
        rd_addr = 1'(w);
        @(negedge clk);
        for (int k = 0; k < 32; k++) e[k] = m_mem[32*w + k];
        chk("rd_model", 64'(rd_data), 64'(e));
        if (use_lit) chk("rd_literal", 64'(rd_data), 64'(lit));
    endtask

    int l0, r0, t0;

    initial begin
        reset = 1'b1; enable = 1'b1; start_re = 1'b0;
        test_delay = CW'(10); test_trig_out_phase = CW'(5);
        test_mask_reset_not = 1'b0; n_frames = FW'(1);
        pattern_bit = 1'b1; dnn_output = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        chk("rst_state", 64'(o_state), 64'(IDLE));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_scan_load", 64'(o_scan_load), 64'(1));
        chk("rst_reset_not", 64'(o_reset_not), 64'(1));
        reset = 1'b0;
        @(negedge clk);

        // One frame, alternating chain data.
        l0 = lowcnt;
        start_run();
        wait_done(4000);
        chk("r1_frame_cnt", 64'(o_frame_cnt), 64'(1));
        chk("r1_resetn_len", 64'(lowcnt - l0), 64'(16));
        rd_chk(0, 32'h5555_5555, 1);
        rd_chk(1, 32'h5555_5555, 1);

        // Three frames, random data, channel 0 hit each frame.
        n_frames = FW'(3); dnn_output = 2'b01; pattern_bit = 1'b0; so_rand = 1;
        r0 = rstcyc; t0 = rises;
        start_run();
        wait_done(8000);
        chk("r2_hits", o_dnn_hits, 64'h0000_0000_0000_0003);
        chk("r2_frame_cnt", 64'(o_frame_cnt), 64'(3));
        chk("r2_resetn_once", 64'(rstcyc - r0), 64'(16));
        chk("r2_trig_rises", 64'(rises - t0), 64'(3));
        rd_chk(0, 32'h0, 0);
        rd_chk(1, 32'h0, 0);

        // Masked ASIC reset.
        n_frames = FW'(1); dnn_output = 2'b11; test_mask_reset_not = 1'b1;
        so_rand = 0; pattern_bit = 1'b1;
        l0 = lowcnt; r0 = rstcyc;
        start_run();
        wait_done(4000);
        chk("r3_no_reset", 64'(lowcnt - l0), 64'(0));
        chk("r3_resetn_len", 64'(rstcyc - r0), 64'(16));
        chk("r3_hits", o_dnn_hits, 64'h0000_0001_0000_0001);
        test_mask_reset_not = 1'b0;

        // Abort mid-shift via enable.
        n_frames = FW'(2);
        start_run();
        wait_bit(20, 4000);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_state", 64'(o_state), 64'(IDLE));
        chk("abort_busy", 64'(o_busy), 64'(0));
        chk("abort_done", 64'(o_done), 64'(0));
        chk("abort_scan_load", 64'(o_scan_load), 64'(1));
        enable = 1'b1;
        @(negedge clk);

        // n_frames=0 runs one frame; start during SHIFT is ignored.
        n_frames = FW'(0);
        start_run();
        wait_bit(5, 4000);
        start_re = 1'b1;
        @(negedge clk) start_re = 1'b0;
        wait_done(4000);
        chk("r5_frame_cnt", 64'(o_frame_cnt), 64'(1));
        chk("r5_done", 64'(o_done), 64'(1));
        rd_chk(0, 32'h5555_5555, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
